// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM states and {s,r} excitation encodings for the SR programming driver.
package sr_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RST     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;
endpackage

// File: rtl/sr_prog_driver_if.sv
// sr_prog_driver_if: request handshake, SR bank drive and status bundle.
// Ports: req_valid/req_data/req_ready request side, q_fb bank readback,
// s_out/r_out bank pulses, busy/done/err status. slave = driver, master = requester/bank.
interface sr_prog_driver_if #(parameter int WIDTH = 8);
  logic             req_valid;
  logic [WIDTH-1:0] req_data;
  logic             req_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic             busy;
  logic             done;
  logic             err;
  modport master (output req_valid, req_data, q_fb,
                  input  req_ready, s_out, r_out, busy, done, err);
  modport slave  (input  req_valid, req_data, q_fb,
                  output req_ready, s_out, r_out, busy, done, err);
endinterface

// File: rtl/sr_excite.sv
// sr_excite: per-bit SR excitation from current q and target to {s,r}; never emits SR_ILLEGAL.
// Ports: q_i current bit, target_i desired bit, sr_o {s,r}.
module sr_excite
  import sr_pkg::*;
(
  input  logic       q_i,
  input  logic       target_i,
  output logic [1:0] sr_o
);
  always_comb sr_o = (q_i == target_i) ? SR_HOLD : (target_i ? SR_SET : SR_RST);
endmodule

// File: rtl/sr_prog_driver.sv
// sr_prog_driver: programs a WIDTH-bit SR flop bank to a requested word, verifying and retrying.
// Ports: clk, rst (sync, active-low), bus (slave modport of sr_prog_driver_if).
module sr_prog_driver
  import sr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst,
  sr_prog_driver_if.slave bus
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d, s_x, r_x;
  logic             done_q, done_d, err_q, err_d;
  for (genvar g = 0; g < WIDTH; g++) begin : g_ex
    logic [1:0] sr;
    sr_excite u_ex (.q_i(bus.q_fb[g]), .target_i(target_q[g]), .sr_o(sr));
    assign s_x[g] = sr[1];
    assign r_x[g] = sr[0];
  end
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    s_d      = '0;
    r_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        target_d = bus.req_data;
        retry_d  = '0;
        state_d  = DRIVE;
      end
      DRIVE: begin
        s_d     = s_x;
        r_d     = r_x;
        state_d = SETTLE;
      end
      SETTLE: state_d = CHECK;
      default: begin
        // X readback bits make the equality unknown, which falls to the retry/err path
        if (bus.q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      retry_q  <= '0;
      s_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s_out     = s_q;
  assign bus.r_out     = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_sr_prog_driver.sv
// tb_sr_prog_driver: directed self-checking bench with an SR flop bank model on the same clk/rst.
module tb_sr_prog_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stuck = 1'b0;
  logic [7:0] q;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sr_prog_driver_if #(.WIDTH(8)) bus ();
  sr_prog_driver #(.WIDTH(8), .MAX_RETRY(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else for (int i = 0; i < 8; i++)
      case ({bus.s_out[i], bus.r_out[i]})
        2'b10: q[i] <= 1'b1;
        2'b01: q[i] <= 1'b0;
        default: q[i] <= q[i];
      endcase
  end
  assign bus.q_fb = stuck ? {q[7:1], 1'b0} : q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) chk("s_and_r_zero", {24'h0, bus.s_out & bus.r_out}, 32'h0);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic [7:0] d, input logic [7:0] es, input logic [7:0] er);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("ready_after_accept", bus.req_ready, 0);
    tick();
    chk("drive_s", bus.s_out, es);
    chk("drive_r", bus.r_out, er);
    tick();
    chk("settle_s", bus.s_out, 0);
    chk("settle_r", bus.r_out, 0);
    chk("settle_done", bus.done, 0);
    tick();
    chk("done_pulse", bus.done, 1);
    chk("no_err", bus.err, 0);
    chk("ready_at_done", bus.req_ready, 1);
    chk("bank_q", q, d);
  endtask
  initial begin
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h77;
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_s", bus.s_out, 0);
    chk("rst_r", bus.r_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    do_req(8'hA5, 8'hA5, 8'h00);
    tick();
    chk("done_one_cycle", bus.done, 0);
    do_req(8'h3C, 8'h18, 8'h81);
    do_req(8'h3C, 8'h00, 8'h00);
    stuck = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h01;
    tick();
    bus.req_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      tick();
      chk("stuck_s", bus.s_out, 8'h01);
      chk("stuck_r", bus.r_out, (a == 0) ? 8'h3C : 8'h00);
      tick();
      tick();
      chk("stuck_done", bus.done, 0);
      chk("stuck_err", bus.err, (a == 3) ? 1 : 0);
    end
    chk("stuck_idle", bus.busy, 0);
    tick();
    chk("err_one_cycle", bus.err, 0);
    stuck = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_data  = 8'hF0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("abort_drive_s", bus.s_out, 8'hF0);
    rst = 1'b0;
    tick();
    chk("abort_s", bus.s_out, 0);
    chk("abort_r", bus.r_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    rst = 1'b1;
    tick();
    chk("abort_done2", bus.done, 0);
    chk("abort_err2", bus.err, 0);
    chk("abort_q", q, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_data  = 8'hFF;
    tick();
    chk("b2b_busy", bus.busy, 1);
    tick();
    chk("b2b_s1", bus.s_out, 8'hFF);
    chk("b2b_ready_busy", bus.req_ready, 0);
    bus.req_data = 8'h00;
    tick();
    chk("b2b_still_busy", bus.busy, 1);
    tick();
    chk("b2b_done1", bus.done, 1);
    chk("b2b_q1", q, 8'hFF);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_accept2", bus.busy, 1);
    chk("b2b_done_cleared", bus.done, 0);
    tick();
    chk("b2b_r2", bus.r_out, 8'hFF);
    chk("b2b_s2", bus.s_out, 8'h00);
    tick();
    tick();
    chk("b2b_done2", bus.done, 1);
    chk("b2b_q2", q, 8'h00);
    tick();
    chk("final_idle", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sr_prog_driver.md
Name: sr_prog_driver

Overview:
- Command-side counterpart of the SR flip-flop bank: accepts a target word over a valid/ready handshake and generates per-bit set/reset pulses from the SR excitation table.
- Reads back the bank's q outputs, verifies the result and retries a bounded number of times.
- Sits between a control register interface and a WIDTH-bit bank of SR flops that share clk and rst.
- Guarantees the forbidden s=1,r=1 combination is never driven.

Parameters:
- WIDTH, 8, number of SR flops driven (bits in target/readback).
- MAX_RETRY, 3, drive/check attempts after the first before err is raised (2-bit counter sized from this).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 sampled at posedge resets).
- req_valid  input  1  target word presented.
- req_data  input  WIDTH  desired q state of the bank.
- req_ready  output  1  driver idle and able to accept; equals (state==IDLE).
- q_fb  input  WIDTH  readback of SR bank q outputs.
- s_out  output  WIDTH  registered set pulses to bank.
- r_out  output  WIDTH  registered reset pulses to bank.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: q_fb matched target.
- err  output  1  one-cycle pulse: retries exhausted, mismatch remains.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, s_out=0, r_out=0, done=0, err=0, retry_cnt=0, target=0. req_valid is ignored while rst==0.
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE: req_ready=1. On req_valid&&req_ready, capture target<=req_data, set retry_cnt=0, go to DRIVE. done/err are cleared here (pulses last one cycle).
- DRIVE: for each bit i, register s_out/r_out from (q_fb[i], target[i]):
  - 0->0: s=0, r=0.
  - 0->1: s=1, r=0.
  - 1->0: s=0, r=1.
  - 1->1: s=0, r=0.
  - Then go to SETTLE.
  - Invariant: (s_out & r_out)==0 in every cycle; the verification bench asserts this.
- SETTLE: the bank samples s/r at this edge. The driver clears s_out=r_out=0 at the same edge and goes to CHECK, so pulses are exactly one cycle wide.
- CHECK: compare q_fb with target.
  - Equal: done=1 for one cycle, go to IDLE.
  - Unequal and retry_cnt<MAX_RETRY: retry_cnt++, go to DRIVE.
  - Unequal and retry_cnt==MAX_RETRY: err=1 for one cycle, go to IDLE.
- Latency: accept edge E0 -> s/r visible after E1 -> bank updates at E2 -> done asserted after E3. Minimum 3 cycles accept-to-done; each retry adds 3.
- Back-to-back: a new request can be accepted in the cycle done/err is high, because state is already IDLE.
- Target equal to current q: DRIVE outputs all zeros and done still follows after 3 cycles (no skip path).
- req_valid while busy: ignored, not queued; the requester holds it until ready.
- req_data changing after accept: no effect; target is latched.
- q_fb X or unknown bits: treated as mismatch by the compare, which leads to retry and then err.
- Reset mid-operation: abort at that edge. Outputs go to reset values immediately and no done/err is issued.

Decomposition:
- Shared package sr_pkg:
  - state enum (IDLE, DRIVE, SETTLE, CHECK).
  - constants SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11, using the {s,r} encoding the flop bank decodes.
- Sub-module sr_excite: purely combinational per-bit excitation mapping from (q, target) to {s,r}, instantiated WIDTH times via generate.
- Top-level holds the FSM, retry counter and output registers.
- Bench instantiates WIDTH SR flops on the same clk/rst as the device under test.

Test Plan:
- Reset then program: rst low 2 cycles, q_fb=8'h00, req_data=8'hA5 -> at DRIVE s_out=8'hA5, r_out=8'h00; done exactly 3 cycles after accept; q=8'hA5.
- Clear/set mix: from q=8'hA5 request 8'h3C -> s_out=8'h18, r_out=8'h81 for one cycle; done; q=8'h3C.
- No-change request: q=8'h3C, request 8'h3C -> s_out=r_out=0 throughout; done after 3 cycles.
- Stuck bit: bench forces q_fb[0]=0, request 8'h01 -> 4 DRIVE pulses (1+MAX_RETRY) each s_out=8'h01; err after 12 cycles, done never high.
- Reset mid-operation: rst low during SETTLE -> next edge s_out=r_out=0, busy=0, req_ready=1, no done/err pulse.
- Back-to-back and busy: hold req_valid with 8'hFF then 8'h00 -> second accepted in the done cycle; req_valid during busy not accepted; (s_out&r_out)==0 asserted every cycle.
